// File: rtl/rvcpu_regfile_sb.sv
// Integer register file with NRD combinational read ports, two write ports
// (A: in-order writeback, B: long-latency writeback) and a per-register busy scoreboard.

module rvcpu_regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREGS-1:0][XLEN-1:0]   regs,
  input  logic [NREGS-1:0]             busy,
  input  logic                         wa_en,
  input  logic [AW-1:0]                wa_addr,
  input  logic [XLEN-1:0]              wa_data,
  input  logic                         wb_en,
  input  logic [AW-1:0]                wb_addr,
  input  logic [XLEN-1:0]              wb_data,
  output logic [XLEN-1:0]              data,
  output logic                         pend
);
  logic wa_hit, wb_hit;

  always_comb begin
    wb_hit = (BYPASS != 0) && wb_en && (wb_addr == addr) && (addr != '0);
    wa_hit = (BYPASS != 0) && wa_en && (wa_addr == addr) && (addr != '0);
    data   = regs[addr];
    if (wb_hit)      data = wb_data;
    else if (wa_hit) data = wa_data;
    // A same-cycle port B write releases the register, so decode need not stall on it.
    pend   = busy[addr] && !wb_hit;
  end
endmodule

module rvcpu_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [AW-1:0]         wa_addr,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_ok,
  input  logic                  flush,
  output logic                  err
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy, busy_eff, busy_nxt, wb_clr, rsv_set;
  logic                       err_nxt;

  // Register 0 is never written, so it reads 0 from reset onward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wa_en && wa_addr != '0) regs[wa_addr] <= wa_data;
      if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_addr] = 1'b1;
    busy_eff = busy & ~wb_clr;
    rsv_ok   = !flush && rsv_en && ((rsv_addr == '0) || !busy_eff[rsv_addr]);
    rsv_set  = '0;
    if (rsv_ok && rsv_addr != '0) rsv_set[rsv_addr] = 1'b1;
    // Set is OR'd after the clear so a same-register reserve wins over the release.
    busy_nxt    = flush ? '0 : (busy_eff | rsv_set);
    busy_nxt[0] = 1'b0;
    err_nxt = (wa_en && wa_addr != '0 && busy[wa_addr]) ||
              (wb_en && wb_addr != '0 && !busy[wb_addr]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err | err_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rvcpu_regfile_sb_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
    ) u_rd (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .wa_en   (wa_en),
      .wa_addr (wa_addr),
      .wa_data (wa_data),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data    (rd_data[k*XLEN +: XLEN]),
      .pend    (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_rvcpu_regfile_sb.sv
// Randomized + directed bench for rvcpu_regfile_sb; a bypass and a non-bypass instance
// share one stimulus stream and one behavioural model.

module tb_rvcpu_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data1, rd_data0;
  logic [NRD-1:0]      rd_busy1, rd_busy0;
  logic                wa_en, wb_en, rsv_en, flush;
  logic [AW-1:0]       wa_addr, wb_addr, rsv_addr;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic                rsv_ok1, rsv_ok0, err1, err0;

  rvcpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok1), .flush(flush), .err(err1));

  rvcpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok0), .flush(flush), .err(err0));

  // Architectural state as seen by software: values, pending destinations, error flag.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_err;
  int              n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wb_en && int'(wb_addr) == a) return wb_data;
    if (byp && wa_en && int'(wa_addr) == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    return m_busy[a] && !(byp && wb_en && int'(wb_addr) == a);
  endfunction

  function automatic bit exp_ok();
    bit released;
    if (flush || !rsv_en) return 1'b0;
    if (rsv_addr == '0) return 1'b1;
    released = wb_en && (wb_addr == rsv_addr);
    return !m_busy[rsv_addr] || released;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    wa_en = 0; wb_en = 0; rsv_en = 0; flush = 0;
    wa_addr = '0; wb_addr = '0; rsv_addr = '0; wa_data = '0; wb_data = '0;
  endtask

  // Compare every output against the model shortly before the next rising edge.
  task automatic settle();
    #3;
    for (int k = 0; k < NRD; k++) begin
      int a;
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("rd_data_byp%0d_x%0d", k, a), 64'(rd_data1[k*XLEN +: XLEN]), 64'(exp_rd(a, 1)));
      chk($sformatf("rd_data_nobyp%0d_x%0d", k, a), 64'(rd_data0[k*XLEN +: XLEN]), 64'(exp_rd(a, 0)));
      chk($sformatf("rd_busy_byp%0d_x%0d", k, a), 64'(rd_busy1[k]), 64'(exp_busy(a, 1)));
      chk($sformatf("rd_busy_nobyp%0d_x%0d", k, a), 64'(rd_busy0[k]), 64'(exp_busy(a, 0)));
    end
    chk("rsv_ok_byp", 64'(rsv_ok1), 64'(exp_ok()));
    chk("rsv_ok_nobyp", 64'(rsv_ok0), 64'(exp_ok()));
    chk("err_byp", 64'(err1), 64'(m_err));
    chk("err_nobyp", 64'(err0), 64'(m_err));
  endtask

  task automatic commit();
    bit ok;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_err = 0;
    end else begin
      ok = exp_ok();
      if (wa_en && wa_addr != '0 && m_busy[wa_addr]) m_err = 1;
      if (wb_en && wb_addr != '0 && !m_busy[wb_addr]) m_err = 1;
      if (wa_en && wa_addr != '0) m_regs[wa_addr] = wa_data;
      if (wb_en && wb_addr != '0) m_regs[wb_addr] = wb_data;
      if (flush) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      end else begin
        if (wb_en) m_busy[wb_addr] = 0;
        if (ok && rsv_addr != '0) m_busy[rsv_addr] = 1;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    commit();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin m_regs[i] = 'x; m_busy[i] = 0; end
    m_err = 0;
    rd_addr = '0;
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    commit();
    rst_n = 1;

    // Every address on every port reads zero and not busy after reset.
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(a ^ 1), AW'(a)};
      settle();
      chk("reset_rd0", 64'(rd_data1[XLEN-1:0]), 64'd0);
      commit();
    end
    chk("reset_err", 64'(err1), 64'd0);

    // Port A write with same-cycle read.
    rd_addr = {AW'(0), AW'(5)};
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    settle();
    chk("wa_bypass", 64'(rd_data1[XLEN-1:0]), 64'hDEADBEEF);
    chk("wa_nobypass_same", 64'(rd_data0[XLEN-1:0]), 64'd0);
    commit();
    idle();
    settle();
    chk("wa_nobypass_next", 64'(rd_data0[XLEN-1:0]), 64'hDEADBEEF);
    commit();

    // Register 0 ignores writes and reservations.
    rd_addr = {AW'(0), AW'(0)};
    wa_en = 1; wa_addr = 0; wa_data = 32'h1234;
    wb_en = 1; wb_addr = 0; wb_data = 32'h1234;
    cyc();
    idle();
    rsv_en = 1; rsv_addr = 0;
    settle();
    chk("x0_rsv_ok", 64'(rsv_ok1), 64'd1);
    chk("x0_rd", 64'(rd_data1[XLEN-1:0]), 64'd0);
    chk("x0_busy", 64'(rd_busy1[0]), 64'd0);
    commit();
    idle();
    settle();
    chk("x0_err", 64'(err1), 64'd0);
    commit();

    // Double reserve is rejected; release + reserve same cycle keeps it busy.
    rd_addr = {AW'(0), AW'(7)};
    rsv_en = 1; rsv_addr = 7;
    cyc();
    settle();
    chk("x7_rsv_again", 64'(rsv_ok1), 64'd0);
    commit();
    wb_en = 1; wb_addr = 7; wb_data = 32'h55;
    settle();
    chk("x7_rel_rsv_ok", 64'(rsv_ok1), 64'd1);
    commit();
    idle();
    settle();
    chk("x7_data", 64'(rd_data0[XLEN-1:0]), 64'h55);
    chk("x7_busy", 64'(rd_busy1[0]), 64'd1);
    chk("x7_err", 64'(err1), 64'd0);
    commit();

    // Write collision on a reserved register: port B data wins and releases it.
    rd_addr = {AW'(0), AW'(3)};
    rsv_en = 1; rsv_addr = 3;
    cyc();
    idle();
    wa_en = 1; wa_addr = 3; wa_data = 32'h11;
    wb_en = 1; wb_addr = 3; wb_data = 32'h22;
    cyc();
    idle();
    settle();
    chk("x3_data", 64'(rd_data0[XLEN-1:0]), 64'h22);
    chk("x3_busy", 64'(rd_busy0[0]), 64'd0);
    commit();

    // Flush drops reservations; a later release is spurious and sticks in err.
    do_reset();
    rd_addr = {AW'(10), AW'(9)};
    rsv_en = 1; rsv_addr = 9;  cyc();
    rsv_addr = 10; cyc();
    rsv_addr = 11; flush = 1;
    settle();
    chk("flush_rsv_ok", 64'(rsv_ok1), 64'd0);
    commit();
    idle();
    settle();
    chk("flush_busy", 64'(rd_busy0), 64'd0);
    chk("flush_err_clear", 64'(err1), 64'd0);
    commit();
    wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("spurious_err", 64'(err1), 64'd1);
      commit();
    end
    do_reset();
    settle();
    chk("err_after_reset", 64'(err1), 64'd0);
    commit();

    // Random traffic, biasing port B releases towards registers that are actually pending.
    for (int i = 0; i < 3000; i++) begin
      int bq[$];
      rst_n = ($urandom_range(0, 149) != 0);
      flush = ($urandom_range(0, 29) == 0);
      wa_en = $urandom_range(0, 1) == 1;
      wa_addr = rnd_addr();
      wa_data = $urandom;
      wb_en = $urandom_range(0, 2) == 0;
      for (int r = 1; r < NREGS; r++) if (m_busy[r]) bq.push_back(r);
      if (bq.size() > 0 && $urandom_range(0, 7) != 0)
        wb_addr = AW'(bq[$urandom_range(0, bq.size()-1)]);
      else
        wb_addr = rnd_addr();
      wb_data = $urandom;
      rsv_en = $urandom_range(0, 1) == 1;
      rsv_addr = rnd_addr();
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0:       rd_addr[k*AW +: AW] = wa_addr;
          1:       rd_addr[k*AW +: AW] = wb_addr;
          default: rd_addr[k*AW +: AW] = rnd_addr();
        endcase
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
